// File: rtl/multicycle_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_pkg
// Shared encodings for the multi-cycle controller: opcodes, FSM states, ALU
// operand/operation selects, PC source selects, and the per-state control word
// with its decode function. Used by the controller, the data path and benches.
// ----------------------------------------------------------------------------
package multicycle_pkg;

    localparam int unsigned OPCODE_W   = 3;
    localparam int unsigned STATE_BITS = 4;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned PERF_W     = 16;

    typedef enum logic [OPCODE_W-1:0] {
        OP_R3    = 3'b000,
        OP_ADDI  = 3'b001,
        OP_LOAD  = 3'b010,
        OP_STORE = 3'b011,
        OP_JUMP  = 3'b100,
        OP_BEQ   = 3'b101,
        OP_LUI   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [STATE_BITS-1:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_I_EXEC    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_LUI_WB    = 4'd11,
        ST_HALT      = 4'd12,
        ST_FAULT     = 4'd13
    } state_t;

    typedef enum logic [SEL_W-1:0] {
        SRCB_REGB = 2'd0,
        SRCB_ONE  = 2'd1,
        SRCB_IMM  = 2'd2
    } alu_src_b_t;

    typedef enum logic [SEL_W-1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

    typedef enum logic [SEL_W-1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_IMM    = 2'd2
    } pc_source_t;

    // Moore part of the control word; input-dependent strobes are qualified
    // at the controller outputs (fetch_strobe by ready, pc_write_zero by zero).
    typedef struct packed {
        logic       fetch_strobe;
        logic       pc_write;
        logic       pc_write_zero;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
        logic       halt;
        logic       fault;
    } ctrl_t;

    // Control word asserted while the FSM sits in state s.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.fetch_strobe = 1'b1;
                c.mem_read     = 1'b1;
                c.alu_src_b    = SRCB_ONE;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_ALU_WB: begin
                c.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REGB;
                c.alu_op        = ALUOP_SUB;
                c.branch        = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.pc_write_zero = 1'b1;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_IMM;
            end
            ST_LUI_WB: begin
                c.reg_write = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_HALT:  c.halt  = 1'b1;
            ST_FAULT: c.fault = 1'b1;
            default:  c.fault = 1'b1;
        endcase
        return c;
    endfunction

    // States that wait on the memory ready handshake.
    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mc_mem_wait_timer
// Counts consecutive not-ready cycles in a memory-wait state and flags the
// cycle in which the count reaches MAX_COUNT.
//   CLK     in  clock
//   Reset   in  asynchronous active-high reset
//   clear   in  restart the count (state entry); has priority over tick
//   tick    in  one more not-ready cycle
//   expired out this tick brings the count to MAX_COUNT (combinational)
// ----------------------------------------------------------------------------
module mc_mem_wait_timer #(
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == LIMIT);
    assign expired    = tick & w_at_limit;

    // Holds at LIMIT; the controller leaves the wait state when expired fires.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick && !w_at_limit) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Control FSM of a multi-cycle processor: sequences fetch, decode, execute,
// memory access and write-back, with a memory-wait watchdog that faults the
// machine after MEM_WAIT_MAX consecutive not-ready cycles.
//   CLK, Reset                 clock, asynchronous active-high reset
//   input_opcode[2:0]          IR[2:0], valid from DECODE onward
//   input_zero                 ALU zero flag
//   input_mem_ready            memory completes the current access
//   output_pc_write/ir_write   PC and IR load strobes
//   output_mem_read/mem_write  memory strobes; output_iord selects ALUOut
//   input_reg_write, memToReg, input_branch   data-path controls
//   output_alu_src_a/_b, output_alu_op, output_pc_source   mux selects
//   output_state, output_halt, output_fault   status
// Optional feature (macro MULTICYCLE_PERF_COUNT_EN): adds saturating 16-bit
// output_cycle_count and output_retire_count.
// ----------------------------------------------------------------------------
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned STATE_W      = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [2:0]         input_opcode,
    input  logic               input_zero,
    input  logic               input_mem_ready,
    output logic               output_pc_write,
    output logic               output_ir_write,
    output logic               output_mem_read,
    output logic               output_mem_write,
    output logic               output_iord,
    output logic               input_reg_write,
    output logic               memToReg,
    output logic               input_branch,
    output logic               output_alu_src_a,
    output logic [1:0]         output_alu_src_b,
    output logic [1:0]         output_alu_op,
    output logic [1:0]         output_pc_source,
    output logic [STATE_W-1:0] output_state,
    output logic               output_halt,
    output logic               output_fault
`ifdef MULTICYCLE_PERF_COUNT_EN
    ,
    output logic [15:0]        output_cycle_count,
    output logic [15:0]        output_retire_count
`endif
);

    state_t  r_state;
    state_t  w_next;
    ctrl_t   r_ctrl;
    opcode_t w_opcode;
    logic    w_tick;
    logic    w_clear;
    logic    w_expired;
    logic    w_run;

    assign w_opcode = opcode_t'(input_opcode);

    // Watchdog counts not-ready cycles only while waiting on memory and
    // restarts whenever the FSM changes state.
    assign w_tick  = is_mem_wait(r_state) & ~input_mem_ready;
    assign w_clear = (w_next != r_state);

    mc_mem_wait_timer #(
        .MAX_COUNT (MEM_WAIT_MAX)
    ) u_wait_timer (
        .CLK     (CLK),
        .Reset   (Reset),
        .clear   (w_clear),
        .tick    (w_tick),
        .expired (w_expired)
    );

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_expired)            w_next = ST_FAULT;
                else if (input_mem_ready) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_opcode)
                    OP_R3:    w_next = ST_R_EXEC;
                    OP_ADDI:  w_next = ST_I_EXEC;
                    OP_LOAD:  w_next = ST_MEM_ADDR;
                    OP_STORE: w_next = ST_MEM_ADDR;
                    OP_JUMP:  w_next = ST_JUMP;
                    OP_BEQ:   w_next = ST_BRANCH;
                    // lui writes back straight from decode
                    OP_LUI:   w_next = ST_LUI_WB;
                    OP_HALT:  w_next = ST_HALT;
                    default:  w_next = ST_FAULT;
                endcase
            end
            ST_MEM_ADDR: begin
                w_next = (w_opcode == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                if (w_expired)            w_next = ST_FAULT;
                else if (input_mem_ready) w_next = ST_MEM_WB;
            end
            ST_MEM_WRITE: begin
                if (w_expired)            w_next = ST_FAULT;
                else if (input_mem_ready) w_next = ST_FETCH;
            end
            ST_R_EXEC:  w_next = ST_ALU_WB;
            ST_I_EXEC:  w_next = ST_ALU_WB;
            ST_MEM_WB:  w_next = ST_FETCH;
            ST_ALU_WB:  w_next = ST_FETCH;
            ST_BRANCH:  w_next = ST_FETCH;
            ST_JUMP:    w_next = ST_FETCH;
            ST_LUI_WB:  w_next = ST_FETCH;
            ST_HALT:    w_next = ST_HALT;
            ST_FAULT:   w_next = ST_FAULT;
            default:    w_next = ST_FAULT;
        endcase
    end

    // State register with the control word registered alongside it.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_FETCH;
            r_ctrl  <= state_ctrl(ST_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
        end
    end

    // The control word already holds FETCH values during reset so the first
    // released cycle fetches; w_run keeps every output low while Reset is high.
    assign w_run = ~Reset;

    // Strobes: PC/IR load only on a completed fetch, memory strobes drop in
    // the cycle the watchdog fires.
    assign output_ir_write  = w_run & r_ctrl.fetch_strobe & input_mem_ready;
    assign output_pc_write  = w_run & (r_ctrl.pc_write
                                     | (r_ctrl.pc_write_zero & input_zero)
                                     | (r_ctrl.fetch_strobe & input_mem_ready));
    assign output_mem_read  = w_run & r_ctrl.mem_read  & ~w_expired;
    assign output_mem_write = w_run & r_ctrl.mem_write & ~w_expired;
    assign input_reg_write  = w_run & r_ctrl.reg_write;
    assign input_branch     = w_run & r_ctrl.branch;

    // Selects and status.
    assign output_iord      = w_run & r_ctrl.iord;
    assign memToReg         = w_run & r_ctrl.mem_to_reg;
    assign output_alu_src_a = w_run & r_ctrl.alu_src_a;
    assign output_alu_src_b = w_run ? 2'(r_ctrl.alu_src_b) : 2'd0;
    assign output_alu_op    = w_run ? 2'(r_ctrl.alu_op)    : 2'd0;
    assign output_pc_source = w_run ? 2'(r_ctrl.pc_source) : 2'd0;
    assign output_halt      = w_run & r_ctrl.halt;
    assign output_fault     = w_run & r_ctrl.fault;
    assign output_state     = STATE_W'(r_state);

`ifdef MULTICYCLE_PERF_COUNT_EN
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    logic [PERF_W-1:0] r_cycle_count;
    logic [PERF_W-1:0] r_retire_count;
    logic              w_count_cycle;
    logic              w_retire;

    assign w_count_cycle = (r_state != ST_HALT) && (r_state != ST_FAULT);
    assign w_retire      = (w_next == ST_FETCH) && (r_state != ST_FETCH);

    // Saturating performance counters.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_cycle_count  <= '0;
            r_retire_count <= '0;
        end else begin
            if (w_count_cycle && (r_cycle_count != PERF_MAX)) begin
                r_cycle_count <= r_cycle_count + PERF_W'(1);
            end
            if (w_retire && (r_retire_count != PERF_MAX)) begin
                r_retire_count <= r_retire_count + PERF_W'(1);
            end
        end
    end

    assign output_cycle_count  = r_cycle_count;
    assign output_retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Directed, table-driven bench for multicycle_control: one record per clock
// cycle with hand-computed state and strobes, plus sequences for the watchdog,
// asynchronous reset during a memory wait, and halt.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int unsigned SW = 4;

    // State codes
    localparam logic [3:0] S_F  = 4'd0,  S_D   = 4'd1,  S_MA = 4'd2,  S_MR = 4'd3;
    localparam logic [3:0] S_MWB = 4'd4, S_MW  = 4'd5,  S_RX = 4'd6,  S_AWB = 4'd7;
    localparam logic [3:0] S_IX = 4'd8,  S_BR  = 4'd9,  S_J  = 4'd10, S_LUI = 4'd11;
    localparam logic [3:0] S_H  = 4'd12, S_FLT = 4'd13;

    // Strobe word {pc_write, ir_write, mem_read, mem_write, reg_write}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] FRDY = 5'b11100;
    localparam logic [4:0] MRD  = 5'b00100;
    localparam logic [4:0] MWR  = 5'b00010;
    localparam logic [4:0] RW   = 5'b00001;
    localparam logic [4:0] PCW  = 5'b10000;

    typedef struct packed {
        logic       rst;
        logic [2:0] op;
        logic       z;
        logic       rdy;
        logic [3:0] st;
        logic [4:0] strb;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, mrd, mwr, rw;
        logic       iord, m2r, br, srca;
        logic [1:0] srcb, aop, psrc;
        logic       halt, fault;
    } obs_t;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [2:0]    input_opcode;
    logic          input_zero;
    logic          input_mem_ready;
    logic          output_pc_write, output_ir_write, output_mem_read, output_mem_write;
    logic          output_iord, input_reg_write, memToReg, input_branch, output_alu_src_a;
    logic [1:0]    output_alu_src_b, output_alu_op, output_pc_source;
    logic [SW-1:0] output_state;
    logic          output_halt, output_fault;
`ifdef MULTICYCLE_PERF_COUNT_EN
    logic [15:0]   output_cycle_count, output_retire_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    multicycle_control #(
        .MEM_WAIT_MAX (15),
        .STATE_W      (SW)
    ) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .input_opcode     (input_opcode),
        .input_zero       (input_zero),
        .input_mem_ready  (input_mem_ready),
        .output_pc_write  (output_pc_write),
        .output_ir_write  (output_ir_write),
        .output_mem_read  (output_mem_read),
        .output_mem_write (output_mem_write),
        .output_iord      (output_iord),
        .input_reg_write  (input_reg_write),
        .memToReg         (memToReg),
        .input_branch     (input_branch),
        .output_alu_src_a (output_alu_src_a),
        .output_alu_src_b (output_alu_src_b),
        .output_alu_op    (output_alu_op),
        .output_pc_source (output_pc_source),
        .output_state     (output_state),
        .output_halt      (output_halt),
        .output_fault     (output_fault)
`ifdef MULTICYCLE_PERF_COUNT_EN
        ,
        .output_cycle_count  (output_cycle_count),
        .output_retire_count (output_retire_count)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic vec_t mk(input logic rst, input logic [2:0] op, input logic z,
                                input logic rdy, input logic [3:0] st, input logic [4:0] strb);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.strb = strb;
        return v;
    endfunction

    // Expected outputs: per-vector state/strobes, per-state mux selects.
    function automatic obs_t exp_obs(input vec_t v);
        obs_t e;
        e = '0;
        if (!v.rst) begin
            e.st = v.st;
            {e.pcw, e.irw, e.mrd, e.mwr, e.rw} = v.strb;
            case (v.st)
                S_F:   e.srcb = 2'd1;
                S_D:   e.srcb = 2'd2;
                S_MA:  begin e.srca = 1'b1; e.srcb = 2'd2; end
                S_MR:  e.iord = 1'b1;
                S_MWB: e.m2r = 1'b1;
                S_MW:  e.iord = 1'b1;
                S_RX:  begin e.srca = 1'b1; e.srcb = 2'd0; e.aop = 2'd2; end
                S_IX:  begin e.srca = 1'b1; e.srcb = 2'd2; e.aop = 2'd0; end
                S_BR:  begin e.srca = 1'b1; e.aop = 2'd1; e.br = 1'b1; e.psrc = 2'd1; end
                S_J:   e.psrc = 2'd2;
                S_LUI: e.srcb = 2'd2;
                S_H:   e.halt = 1'b1;
                S_FLT: e.fault = 1'b1;
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t g;
        g.st = output_state;
        g.pcw = output_pc_write;  g.irw = output_ir_write;
        g.mrd = output_mem_read;  g.mwr = output_mem_write;
        g.rw = input_reg_write;   g.iord = output_iord;
        g.m2r = memToReg;         g.br = input_branch;
        g.srca = output_alu_src_a; g.srcb = output_alu_src_b;
        g.aop = output_alu_op;    g.psrc = output_pc_source;
        g.halt = output_halt;     g.fault = output_fault;
        return g;
    endfunction

    task automatic check_obs(input string tag, input int idx, input obs_t e);
        obs_t g;
        g = sample();
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s[%0d] got state=%0d word=%h, expected state=%0d word=%h",
                     tag, idx, g.st, g, e.st, e);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] e);
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", tag, got, e);
        end
    endtask

    // Drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic apply(input vec_t v, input string tag, input int idx);
        Reset = v.rst; input_opcode = v.op; input_zero = v.z; input_mem_ready = v.rdy;
        @(negedge CLK);
        check_obs(tag, idx, exp_obs(v));
        @(posedge CLK);
        #1;
    endtask

    vec_t vq[$];

    initial begin
        Reset = 1'b1; input_opcode = 3'b000; input_zero = 1'b0; input_mem_ready = 1'b0;
        @(posedge CLK);
        #1;

        // ---------------- main table ----------------
        vq.push_back(mk(1, 3'b001, 0, 1, S_F, NONE));
        // addi: 0,1,8,7
        vq.push_back(mk(0, 3'b001, 0, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b001, 0, 1, S_D, NONE));
        vq.push_back(mk(0, 3'b001, 0, 1, S_IX, NONE));
        vq.push_back(mk(0, 3'b001, 0, 1, S_AWB, RW));
        // 3R with zero high (must not write PC)
        vq.push_back(mk(0, 3'b000, 1, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b000, 1, 1, S_D, NONE));
        vq.push_back(mk(0, 3'b000, 1, 1, S_RX, NONE));
        vq.push_back(mk(0, 3'b000, 1, 1, S_AWB, RW));
        // beq taken
        vq.push_back(mk(0, 3'b101, 1, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b101, 1, 1, S_D, NONE));
        vq.push_back(mk(0, 3'b101, 1, 1, S_BR, PCW));
        // beq not taken
        vq.push_back(mk(0, 3'b101, 0, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b101, 0, 1, S_D, NONE));
        vq.push_back(mk(0, 3'b101, 0, 1, S_BR, NONE));
        // jump
        vq.push_back(mk(0, 3'b100, 0, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b100, 0, 1, S_D, NONE));
        vq.push_back(mk(0, 3'b100, 0, 1, S_J, PCW));
        // lui
        vq.push_back(mk(0, 3'b110, 0, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b110, 0, 1, S_D, NONE));
        vq.push_back(mk(0, 3'b110, 0, 1, S_LUI, RW));
        // load with three not-ready cycles in MEM_READ (8 cycles total)
        vq.push_back(mk(0, 3'b010, 0, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b010, 0, 1, S_D, NONE));
        vq.push_back(mk(0, 3'b010, 0, 0, S_MA, NONE));
        vq.push_back(mk(0, 3'b010, 0, 0, S_MR, MRD));
        vq.push_back(mk(0, 3'b010, 0, 0, S_MR, MRD));
        vq.push_back(mk(0, 3'b010, 0, 0, S_MR, MRD));
        vq.push_back(mk(0, 3'b010, 0, 1, S_MR, MRD));
        vq.push_back(mk(0, 3'b010, 0, 1, S_MWB, RW));
        // store, zero-wait
        vq.push_back(mk(0, 3'b011, 0, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b011, 0, 1, S_D, NONE));
        vq.push_back(mk(0, 3'b011, 0, 1, S_MA, NONE));
        vq.push_back(mk(0, 3'b011, 0, 1, S_MW, MWR));
        // fetch waits one cycle, then halt (ready ignored in DECODE/HALT)
        vq.push_back(mk(0, 3'b111, 0, 0, S_F, MRD));
        vq.push_back(mk(0, 3'b111, 0, 1, S_F, FRDY));
        vq.push_back(mk(0, 3'b111, 0, 0, S_D, NONE));
        vq.push_back(mk(0, 3'b111, 0, 1, S_H, NONE));
        vq.push_back(mk(0, 3'b111, 0, 0, S_H, NONE));
        // reset exits halt
        vq.push_back(mk(1, 3'b001, 0, 1, S_F, NONE));
        vq.push_back(mk(0, 3'b001, 0, 1, S_F, FRDY));

        for (int i = 0; i < vq.size(); i++) apply(vq[i], "table", i);

        // ---------------- watchdog: 15 not-ready fetch cycles ----------------
        apply(mk(1, 3'b000, 0, 0, S_F, NONE), "flt_rst", 0);
        for (int k = 1; k <= 14; k++) apply(mk(0, 3'b000, 0, 0, S_F, MRD), "flt_wait", k);
        apply(mk(0, 3'b000, 0, 0, S_F, NONE), "flt_expire", 15);
        for (int k = 0; k < 3; k++) apply(mk(0, 3'b000, 0, 1, S_FLT, NONE), "flt_hold", k);
        apply(mk(1, 3'b000, 0, 1, S_F, NONE), "flt_reset", 0);
        apply(mk(0, 3'b000, 0, 0, S_F, MRD), "flt_release", 0);

        // ---------------- 14 waits is not a fault; counter restarts per state --------
        apply(mk(1, 3'b010, 0, 0, S_F, NONE), "bnd_rst", 0);
        for (int k = 1; k <= 14; k++) apply(mk(0, 3'b010, 0, 0, S_F, MRD), "bnd_fwait", k);
        apply(mk(0, 3'b010, 0, 1, S_F, FRDY), "bnd_fetch", 0);
        apply(mk(0, 3'b010, 0, 1, S_D, NONE), "bnd_dec", 0);
        apply(mk(0, 3'b010, 0, 1, S_MA, NONE), "bnd_addr", 0);
        for (int k = 1; k <= 14; k++) apply(mk(0, 3'b010, 0, 0, S_MR, MRD), "bnd_rwait", k);
        apply(mk(0, 3'b010, 0, 1, S_MR, MRD), "bnd_read", 0);
        apply(mk(0, 3'b010, 0, 1, S_MWB, RW), "bnd_wb", 0);

        // ---------------- async reset during MEM_WRITE wait ----------------
        apply(mk(1, 3'b011, 0, 1, S_F, NONE), "arst_rst", 0);
        apply(mk(0, 3'b011, 0, 1, S_F, FRDY), "arst_fetch", 0);
        apply(mk(0, 3'b011, 0, 1, S_D, NONE), "arst_dec", 0);
        apply(mk(0, 3'b011, 0, 0, S_MA, NONE), "arst_addr", 0);
        for (int k = 0; k < 3; k++) apply(mk(0, 3'b011, 0, 0, S_MW, MWR), "arst_wwait", k);
        #2;
        Reset = 1'b1;
        #1;
        check_obs("arst_immediate", 0, '0);
        @(negedge CLK);
        check_obs("arst_held", 0, '0);
        @(posedge CLK);
        #1;
        apply(mk(0, 3'b011, 0, 0, S_F, MRD), "arst_release", 0);

        // ---------------- addi then halt, held 20 cycles ----------------
        apply(mk(1, 3'b001, 0, 1, S_F, NONE), "halt_rst", 0);
        apply(mk(0, 3'b001, 0, 1, S_F, FRDY), "halt_f1", 0);
        apply(mk(0, 3'b001, 0, 1, S_D, NONE), "halt_d1", 0);
        apply(mk(0, 3'b001, 0, 1, S_IX, NONE), "halt_ix", 0);
        apply(mk(0, 3'b001, 0, 1, S_AWB, RW), "halt_wb", 0);
        apply(mk(0, 3'b111, 0, 1, S_F, FRDY), "halt_f2", 0);
        apply(mk(0, 3'b111, 0, 1, S_D, NONE), "halt_d2", 0);
        apply(mk(0, 3'b111, 1, 1, S_H, NONE), "halt_hold", 0);
`ifdef MULTICYCLE_PERF_COUNT_EN
        check16("perf_cycles_at_halt", output_cycle_count, 16'd6);
        check16("perf_retire_at_halt", output_retire_count, 16'd1);
`endif
        for (int k = 1; k < 20; k++) begin
            apply(mk(0, 3'b111, k[0], k[1], S_H, NONE), "halt_hold", k);
        end
`ifdef MULTICYCLE_PERF_COUNT_EN
        check16("perf_cycles_after_halt", output_cycle_count, 16'd6);
        check16("perf_retire_after_halt", output_retire_count, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
